// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: start/busy/done handshake and operand/result bundle for the divider.
interface seq_signed_divider_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: radix-2 restoring signed divider, truncating toward zero, start/busy/done handshake.
module seq_signed_divider #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    seq_signed_divider_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);
    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p, d_mag, a_mag, b_mag, shifted;
    logic [WIDTH+1:0] t;
    logic [WIDTH-1:0] qm, dvd;
    logic             sign_q, sign_r, dz, ov;
    // Magnitudes carry one extra bit so |MIN| needs no special casing.
    always_comb begin
        a_mag   = bus.dividend[WIDTH-1] ? -{1'b1, bus.dividend} : {1'b0, bus.dividend};
        b_mag   = bus.divisor[WIDTH-1] ? -{1'b1, bus.divisor} : {1'b0, bus.divisor};
        shifted = {p[WIDTH-1:0], qm[WIDTH-1]};
        t       = {1'b0, shifted} - {1'b0, d_mag};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            p               <= '0;
            d_mag           <= '0;
            qm              <= '0;
            dvd             <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            dz              <= 1'b0;
            ov              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    qm       <= a_mag[WIDTH-1:0];
                    d_mag    <= b_mag;
                    dvd      <= bus.dividend;
                    sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    sign_r   <= bus.dividend[WIDTH-1];
                    p        <= '0;
                    count    <= CW'(WIDTH);
                    bus.busy <= 1'b1;
                    dz       <= bus.divisor == '0;
                    ov       <= bus.dividend == {1'b1, {(WIDTH-1){1'b0}}} && bus.divisor == '1;
                    state    <= (bus.divisor == '0) ? FIX : CALC;
                end
            end else if (state == CALC) begin
                p     <= t[WIDTH+1] ? shifted : t[WIDTH:0];
                qm    <= {qm[WIDTH-2:0], ~t[WIDTH+1]};
                count <= count - 1'b1;
                state <= (count == CW'(1)) ? FIX : CALC;
            end else begin
                bus.quotient    <= dz ? '1 : (sign_q ? -qm : qm);
                bus.remainder   <= dz ? dvd : (sign_r ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
                bus.div_by_zero <= dz;
                bus.overflow    <= ov & ~dz;
                bus.done        <= 1'b1;
                bus.busy        <= 1'b0;
                state           <= IDLE;
            end
        end
    end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed integer divider; the inverse datapath to the team's sequential Booth multiplier.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using radix-2 restoring division on magnitudes, followed by a sign fix-up.
- Sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake.
- Division truncates toward zero (C semantics); the remainder takes the dividend's sign.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits (>=4)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed dividend, sampled with start
divisor  input  WIDTH  signed divisor, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient, held until next done
remainder  output  WIDTH  signed remainder, held until next done
div_by_zero  output  1  status for the last completed operation
overflow  output  1  status for the last completed operation (MIN / -1)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; internal registers cleared.
- Reset mid-operation aborts the operation immediately. No done is produced for the aborted request.
- States: IDLE, CALC, FIX.
- IDLE, start=1 (edge E0):
  - Latch |dividend| and |divisor| as WIDTH+1-bit magnitudes, so MIN is representable.
  - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder P (WIDTH+1 bits); load count=WIDTH; busy<=1.
  - If divisor==0: record dz, go to FIX. Otherwise go to CALC.
- IDLE, start=0: hold state. Outputs unchanged; done=0.
- CALC, one iteration per edge:
  - Shift {P,Qm} left by 1.
  - T = P - |divisor|. If T>=0, then P<=T and Qm[0]<=1; else restore P and Qm[0]<=0.
  - count decrements. When count reaches 0 after the WIDTH-th iteration, go to FIX.
  - Exactly WIDTH edges are spent in CALC.
- FIX, one edge; registers the outputs and sets done<=1, busy<=0, next state=IDLE:
  - Normal case: quotient = sign_q ? -Qm : Qm; remainder = sign_r ? -P : P (both truncated to WIDTH).
  - Divide by zero: quotient = all ones; remainder = dividend; div_by_zero=1; overflow=0.
  - MIN / -1: quotient = MIN (wrapped); remainder = 0; overflow=1.
  - div_by_zero and overflow are otherwise 0, and are updated only at FIX.
- Latency:
  - Normal case: done is high in the cycle after edge E0+WIDTH+1. That is 17 cycles for WIDTH=16.
  - Divide by zero: done follows edge E0+1.
  - busy is high from after E0 until done rises, and is never high together with done.
- start while busy is ignored; operands are not re-sampled.
- start in the done cycle: the FSM is already IDLE, so the request is accepted. Back-to-back throughput is WIDTH+2 cycles per operation.
- Operand inputs may change freely after E0.
- Outputs hold their last values until the next FIX.

Test Plan:
- 100 / 7, start pulsed one cycle -> busy for 17 cycles, then done for exactly 1 cycle; quotient=14, remainder=2, both flags 0.
- Sign combinations:
  - -100 / 7 -> quotient=-14, remainder=-2.
  - 100 / -7 -> quotient=-14, remainder=2.
  - -100 / -7 -> quotient=14, remainder=-2.
- -32768 / -1 -> quotient=0x8000, remainder=0, overflow=1. Also -32768 / 1 -> quotient=0x8000, overflow=0.
- 5 / 0 -> done 2 cycles after the start edge; quotient=0xFFFF, remainder=5, div_by_zero=1. The next op, 9 / 3, clears the flag: quotient=3, remainder=0.
- start re-asserted with 50 / 5 while busy on 100 / 7 -> the second request is ignored; results are 14 / 2 only. A new start in the done cycle is accepted and yields 10 / 0.
- rst asserted at iteration 8 -> all outputs 0 asynchronously and no done pulse; after release, 7 / 2 -> quotient=3, remainder=1.
